seq_gen_101: RTL and testbench
==============================

// Module: seq_gen_101
// PURPOSE
//  Serial stimulus transmitter for the "101" sequence detectors: accepts a parallel word via
//  valid/ready, shifts it out MSB-first on x, one bit per clk. Also produces y_exp, the golden
//  overlapping-Mealy "101" flag for the emitted stream, and a per-frame match count.
//  Sits upstream of seq_det_101_mealy / seq_det_101_moore; x drives their x input directly.
// PARAMETERS
//  WIDTH     16  max frame length in bits (>=2)
//  LEN_W     5   width of load_len; must hold WIDTH-1
//  CNT_W     8   width of match_cnt (saturating)
//  IDLE_BIT  0   level driven on x when no frame is being shifted
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  load_valid  in   1       frame offered on load_data/load_len
//  load_ready  out  1       1 = block accepts a frame this cycle
//  load_data   in   WIDTH   frame bits; low load_len bits used, MSB of that field sent first
//  load_len    in   LEN_W   frame length in bits; 0 means WIDTH
//  abort       in   1       terminate current frame after the bit now on x
//  x           out  1       serial bit stream (registered)
//  x_valid     out  1       1 = x carries a frame bit
//  frame_done  out  1       one-cycle pulse after last (or aborted) bit
//  y_exp       out  1       expected Mealy detector output for the current x
//  match_cnt   out  CNT_W   "101" matches in current/last frame
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, x=IDLE_BIT, x_valid=0, frame_done=0, load_ready=1,
//   match_cnt=0, history h1=h0=IDLE_BIT, so y_exp=0. Reset mid-frame drops the frame.
//  FSM states IDLE, SHIFT, DONE. load_ready = (state==IDLE); no other state accepts.
//  IDLE: on load_valid&&load_ready at edge N: latch shift reg = load_data << (WIDTH-L),
//   L = (load_len==0)?WIDTH:load_len, bit counter = L, match_cnt cleared -> SHIFT.
//   load_len > WIDTH is treated as WIDTH.
//  SHIFT: from edge N+1, x = shreg[WIDTH-1], x_valid=1, shift left each cycle; bit k of frame
//   (k=0..L-1) is on x in cycle N+1+k. After the cycle carrying bit L-1 -> DONE.
//  abort: sampled in SHIFT; the bit currently on x completes, next cycle is DONE. Ignored in
//   IDLE/DONE. abort on last bit = normal completion.
//  DONE (exactly one cycle): x=IDLE_BIT, x_valid=0, frame_done=1 -> IDLE. Min gap between the
//   last bit of one frame and the first bit of the next = 2 cycles (DONE + IDLE accept).
//  load_valid outside IDLE ignored; load_data/load_len need not be held after acceptance.
//  Golden model: h0/h1 = x one / two cycles earlier, updated every cycle incl. idle cycles
//   (detector sees the full line). y_exp = x & ~h0 & h1, combinational from registers.
//   Overlap counts: 10101 gives two matches.
//  match_cnt: +1 on each cycle with x_valid && y_exp; saturates at 2^CNT_W-1; holds after
//   frame end until next acceptance clears it. A match whose "1","0" came from the previous
//   frame is counted only if its final "1" has x_valid=1.
//  No combinational path from inputs to x, x_valid, frame_done, y_exp, match_cnt.
// TESTING
//  1 rst=0 mid-frame (after 2 bits of a 8-bit frame) -> same cycle x=0,x_valid=0,load_ready=1,
//    match_cnt=0; after release, next load accepted normally.
//  2 load_data=16'h0005, load_len=3 -> x=1,0,1 on 3 consecutive cycles with x_valid=1,
//    y_exp=1 on third bit only, match_cnt=1, frame_done pulse next cycle, load_ready=1 after.
//  3 load_data=16'h00AA, load_len=8 -> x=1,0,1,0,1,0,1,0; y_exp=1 on bits 2,4,6;
//    match_cnt=3 (overlap).
//  4 load_len=0, load_data=16'hFFFF -> 16 ones, x_valid high 16 cycles, match_cnt=0;
//    then load_len=0, data=16'hA000 -> first bits 1,0,1, match_cnt=1.
//  5 load_valid held high throughout SHIFT with new data -> ignored until IDLE; abort asserted
//    during bit 3 of a 8-bit frame -> bit 3 sent, next cycle x=IDLE_BIT, frame_done=1.
//  6 Connect x to both detectors: bench checks y_mealy==y_exp every cycle after reset for
//    random frames (len 1..16, random gaps); match_cnt saturates at 255 with CNT_W=8 over
//    long runs of 10101... when WIDTH is raised to 600 in a separate build.

Source files
------------

// File: rtl/seq_gen_101.sv
// seq_gen_101: serial "101" stimulus transmitter. Shifts accepted frames out MSB-first on x,
// and alongside produces the golden overlapping-Mealy "101" flag plus a per-frame match count.
module seq_gen_101 #(
    parameter int   WIDTH    = 16,
    parameter int   LEN_W    = 5,
    parameter int   CNT_W    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done,
    output logic             y_exp,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int BC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] shreg_r;
    logic [BC_W-1:0]  bit_cnt_r;
    logic [BC_W-1:0]  len_s;
    logic             x_r;
    logic             x_valid_r;
    logic             frame_done_r;
    logic             h0_r;
    logic             h1_r;
    logic [CNT_W-1:0] match_cnt_r;
    logic             accept_s;
    logic             emit_s;
    logic             finish_s;
    logic             y_exp_s;

    // A length field of zero, or one larger than the shift register, means a full-width frame.
    function automatic logic [BC_W-1:0] frame_len(input logic [LEN_W-1:0] len);
        logic [BC_W-1:0] l;
        if (len == {LEN_W{1'b0}} || int'(len) > WIDTH) begin
            l = BC_W'(WIDTH);
        end else begin
            l = BC_W'(len);
        end
        return l;
    endfunction

    assign len_s = frame_len(load_len);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control strobes; abort only counts once a frame bit is actually on the line.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        emit_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == {BC_W{1'b0}} || (abort && x_valid_r)) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    emit_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Shift datapath and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r      <= {WIDTH{1'b0}};
            bit_cnt_r    <= {BC_W{1'b0}};
            x_r          <= IDLE_BIT;
            x_valid_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= finish_s;
            if (accept_s) begin
                shreg_r   <= load_data << (WIDTH - int'(len_s));
                bit_cnt_r <= len_s;
                x_r       <= IDLE_BIT;
                x_valid_r <= 1'b0;
            end else if (emit_s) begin
                shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
                bit_cnt_r <= bit_cnt_r - BC_W'(1);
                x_r       <= shreg_r[WIDTH-1];
                x_valid_r <= 1'b1;
            end else begin
                x_r       <= IDLE_BIT;
                x_valid_r <= 1'b0;
            end
        end
    end

    // Line history runs every cycle so the golden flag sees idle bits exactly as a detector would.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h0_r <= IDLE_BIT;
            h1_r <= IDLE_BIT;
        end else begin
            h0_r <= x_r;
            h1_r <= h0_r;
        end
    end

    assign y_exp_s = x_r & ~h0_r & h1_r;

    // Saturating match counter, cleared on frame acceptance and held after the frame ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (x_valid_r && y_exp_s && (match_cnt_r != {CNT_W{1'b1}})) begin
            match_cnt_r <= match_cnt_r + CNT_W'(1);
        end
    end

    assign load_ready = (state_r == ST_IDLE);
    assign x          = x_r;
    assign x_valid    = x_valid_r;
    assign frame_done = frame_done_r;
    assign y_exp      = y_exp_s;
    assign match_cnt  = match_cnt_r;

endmodule

// File: tb/tb_seq_gen_101.sv
// Self-checking bench for seq_gen_101: directed frames plus randomized frames, gaps and aborts,
// checked cycle by cycle against a line-level "101" reference model.
module tb_seq_gen_101;

    localparam int   WIDTH    = 16;
    localparam int   LEN_W    = 5;
    localparam int   CNT_W    = 8;
    localparam logic IDLE_BIT = 1'b0;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             frame_done;
    logic             y_exp;
    logic [CNT_W-1:0] match_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // Reference line: expected x this cycle and the two previous cycles.
    logic             ex_x;
    logic             lp1;
    logic             lp2;
    logic [CNT_W-1:0] last_cnt;

    always #5 clk = ~clk;

    seq_gen_101 #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .abort(abort), .x(x),
        .x_valid(x_valid), .frame_done(frame_done), .y_exp(y_exp), .match_cnt(match_cnt)
    );

    task automatic model_reset();
        ex_x     = IDLE_BIT;
        lp1      = IDLE_BIT;
        lp2      = IDLE_BIT;
        last_cnt = '0;
    endtask

    // Advance one clock; the line defaults to idle unless the caller places a frame bit.
    task automatic tick();
        @(posedge clk);
        #1;
        lp2  = lp1;
        lp1  = ex_x;
        ex_x = IDLE_BIT;
    endtask

    function automatic logic model_y();
        return ({lp2, lp1, ex_x} == 3'b101);
    endfunction

    task automatic run_frame(input logic [WIDTH-1:0] data, input int lenf, input int abort_at,
                             input bit hold_valid, input string tag);
        int               L;
        int               nbits;
        logic [4:0]       got;
        logic [4:0]       expv;
        logic [CNT_W-1:0] exp_cnt;
        logic             ey;
        L       = (lenf == 0 || lenf > WIDTH) ? WIDTH : lenf;
        nbits   = (abort_at >= 0 && abort_at < L) ? abort_at + 1 : L;
        exp_cnt = '0;
        n_total++;
        if (load_ready !== 1'b1) $display("FAIL %s accept: load_ready=%b expected 1", tag, load_ready);
        else n_pass++;
        load_valid = 1'b1;
        load_data  = data;
        load_len   = LEN_W'(lenf);
        abort      = 1'b0;
        tick();
        load_valid = hold_valid;
        load_data  = WIDTH'($urandom);
        load_len   = LEN_W'($urandom);
        got  = {x, x_valid, y_exp, frame_done, load_ready};
        expv = {IDLE_BIT, 1'b0, model_y(), 1'b0, 1'b0};
        n_total++;
        if (got !== expv) $display("FAIL %s lead {x,xv,y,done,rdy}: got %b expected %b", tag, got, expv);
        else n_pass++;
        n_total++;
        if (match_cnt !== exp_cnt) $display("FAIL %s clear match_cnt: got %0d expected %0d", tag, match_cnt, exp_cnt);
        else n_pass++;
        for (int k = 0; k < nbits; k++) begin
            tick();
            ex_x = data[L-1-k];
            ey   = model_y();
            got  = {x, x_valid, y_exp, frame_done, load_ready};
            expv = {ex_x, 1'b1, ey, 1'b0, 1'b0};
            n_total++;
            if (got !== expv) $display("FAIL %s bit%0d {x,xv,y,done,rdy}: got %b expected %b", tag, k, got, expv);
            else n_pass++;
            n_total++;
            if (match_cnt !== exp_cnt) $display("FAIL %s bit%0d match_cnt: got %0d expected %0d", tag, k, match_cnt, exp_cnt);
            else n_pass++;
            if (ey && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
            abort = (k == abort_at);
            if (hold_valid) load_data = WIDTH'($urandom);
        end
        tick();
        load_valid = 1'b0;
        abort      = 1'b0;
        got  = {x, x_valid, y_exp, frame_done, load_ready};
        expv = {IDLE_BIT, 1'b0, model_y(), 1'b1, 1'b0};
        n_total++;
        if (got !== expv) $display("FAIL %s done {x,xv,y,done,rdy}: got %b expected %b", tag, got, expv);
        else n_pass++;
        n_total++;
        if (match_cnt !== exp_cnt) $display("FAIL %s done match_cnt: got %0d expected %0d", tag, match_cnt, exp_cnt);
        else n_pass++;
        tick();
        got  = {x, x_valid, y_exp, frame_done, load_ready};
        expv = {IDLE_BIT, 1'b0, model_y(), 1'b0, 1'b1};
        n_total++;
        if (got !== expv) $display("FAIL %s idle {x,xv,y,done,rdy}: got %b expected %b", tag, got, expv);
        else n_pass++;
        last_cnt = exp_cnt;
    endtask

    task automatic idle(input int n, input bit rnd_abort);
        logic [4:0] got;
        logic [4:0] expv;
        for (int i = 0; i < n; i++) begin
            abort = rnd_abort ? 1'($urandom) : 1'b0;
            tick();
            got  = {x, x_valid, y_exp, frame_done, load_ready};
            expv = {IDLE_BIT, 1'b0, model_y(), 1'b0, 1'b1};
            n_total++;
            if (got !== expv) $display("FAIL gap {x,xv,y,done,rdy}: got %b expected %b", got, expv);
            else n_pass++;
            n_total++;
            if (match_cnt !== last_cnt) $display("FAIL gap match_cnt hold: got %0d expected %0d", match_cnt, last_cnt);
            else n_pass++;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        #3;
        got = {x, x_valid, load_ready, frame_done, y_exp};
        n_total++;
        if (got !== {IDLE_BIT, 4'b0100}) $display("FAIL reset {x,xv,rdy,done,y}: got %b expected %b", got, {IDLE_BIT, 4'b0100});
        else n_pass++;
        n_total++;
        if (match_cnt !== 8'd0) $display("FAIL reset match_cnt: got %0d expected 0", match_cnt);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h00A5;
        load_len   = 5'd8;
        tick();
        load_valid = 1'b0;
        tick();
        ex_x = 1'b1;
        tick();
        ex_x = 1'b0;
        n_total++;
        if ({x, x_valid} !== 2'b01) $display("FAIL midframe bit1 {x,xv}: got %b expected 01", {x, x_valid});
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        got = {x, x_valid, load_ready, frame_done, y_exp};
        n_total++;
        if (got !== {IDLE_BIT, 4'b0100}) $display("FAIL midframe reset {x,xv,rdy,done,y}: got %b expected %b", got, {IDLE_BIT, 4'b0100});
        else n_pass++;
        n_total++;
        if (match_cnt !== 8'd0) $display("FAIL midframe reset match_cnt: got %0d expected 0", match_cnt);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_frame(16'h00C3, 8, -1, 1'b0, "after_reset");
    endtask

    task automatic test_len3();
        run_frame(16'h0005, 3, -1, 1'b0, "len3");
        n_total++;
        if (match_cnt !== 8'd1) $display("FAIL len3 final match_cnt: got %0d expected 1", match_cnt);
        else n_pass++;
    endtask

    task automatic test_overlap();
        run_frame(16'h00AA, 8, -1, 1'b0, "overlap");
        n_total++;
        if (match_cnt !== 8'd3) $display("FAIL overlap final match_cnt: got %0d expected 3", match_cnt);
        else n_pass++;
    endtask

    task automatic test_full_width();
        run_frame(16'hFFFF, 0, -1, 1'b0, "full_ones");
        n_total++;
        if (match_cnt !== 8'd0) $display("FAIL full_ones final match_cnt: got %0d expected 0", match_cnt);
        else n_pass++;
        run_frame(16'hA000, 0, -1, 1'b0, "full_a000");
        n_total++;
        if (match_cnt !== 8'd1) $display("FAIL full_a000 final match_cnt: got %0d expected 1", match_cnt);
        else n_pass++;
        run_frame(16'h5555, 31, -1, 1'b0, "len_over");
    endtask

    task automatic test_abort_hold();
        run_frame(16'h00B5, 8, 3, 1'b1, "abort_hold");
        run_frame(16'h0015, 5, 4, 1'b0, "abort_last");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 50; i++) begin
            run_frame(WIDTH'($urandom), int'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                      1'($urandom), "random");
            idle(int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        abort      = 1'b0;
        model_reset();
        test_reset();
        test_len3();
        test_overlap();
        test_full_width();
        test_abort_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
